// File: rtl/beep_pkg.sv
// Shared types and 100 MHz default timing for the buzzer tone-burst driver.
package beep_pkg;

  typedef enum logic [1:0] {IDLE, ON, OFF} beep_state_t;

  localparam int unsigned DEF_TONE_HALF = 25_000;
  localparam int unsigned DEF_ON_CYC    = 20_000_000;
  localparam int unsigned DEF_OFF_CYC   = 30_000_000;
  localparam int unsigned DEF_MAX_BEEPS = 12;

  function automatic logic [3:0] clamp_beeps(input logic [3:0] n, input logic [3:0] max_n);
    return (n > max_n) ? max_n : n;
  endfunction

endpackage

// File: rtl/beep_gen_tone_div.sv
// Square-wave divider: restarts high on clr, toggles every TONE_HALF enabled
// cycles, and falls to 0 at once whenever it is neither cleared nor enabled.
module tone_div #(
  parameter int unsigned TONE_HALF = 25_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tone
);
  localparam int unsigned PH_W = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

  logic [PH_W-1:0] ph;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph   <= '0;
      tone <= 1'b0;
    end else if (clr) begin
      ph   <= '0;
      tone <= 1'b1;
    end else if (en) begin
      if (ph == PH_W'(TONE_HALF - 1)) begin
        ph   <= '0;
        tone <= ~tone;
      end else begin
        ph <= ph + PH_W'(1);
      end
    end else begin
      ph   <= '0;
      tone <= 1'b0;
    end
  end

endmodule

// File: rtl/beep_gen.sv
// Buzzer tone-burst sequencer: N beeps of ON tone / OFF silence, abortable by stop.
module beep_gen
  import beep_pkg::*;
#(
  parameter int unsigned TONE_HALF = DEF_TONE_HALF,
  parameter int unsigned ON_CYC    = DEF_ON_CYC,
  parameter int unsigned OFF_CYC   = DEF_OFF_CYC,
  parameter int unsigned MAX_BEEPS = DEF_MAX_BEEPS
) (
  input  logic       clk_100MHz,
  input  logic       rst_beep,
  input  logic       start,
  input  logic [3:0] beep_cnt,
  input  logic       stop,
  output logic       buzzer,
  output logic       beep_busy,
  output logic       beep_done
);
  localparam int unsigned DUR_MAX = ((ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC) - 1;
  localparam int unsigned DUR_W   = (DUR_MAX > 0) ? $clog2(DUR_MAX + 1) : 1;

  beep_state_t      state_q, state_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [3:0]       rem_q, rem_d;
  logic             done_d, busy_d;
  logic             tone_en, tone_clr;

  always_ff @(posedge clk_100MHz or negedge rst_beep) begin
    if (!rst_beep) begin
      state_q   <= IDLE;
      dur_q     <= '0;
      rem_q     <= '0;
      beep_done <= 1'b0;
      beep_busy <= 1'b0;
    end else begin
      state_q   <= state_d;
      dur_q     <= dur_d;
      rem_q     <= rem_d;
      beep_done <= done_d;
      beep_busy <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dur_d    = dur_q;
    rem_d    = rem_q;
    done_d   = 1'b0;
    tone_en  = 1'b0;
    tone_clr = 1'b0;
    if (stop) begin
      state_d = IDLE;
      dur_d   = '0;
      rem_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && beep_cnt != 4'd0) begin
            state_d  = ON;
            dur_d    = '0;
            rem_d    = clamp_beeps(beep_cnt, 4'(MAX_BEEPS));
            tone_clr = 1'b1;
          end
        end
        ON: begin
          if (dur_q == DUR_W'(ON_CYC - 1)) begin
            dur_d = '0;
            if (rem_q == 4'd1) begin
              state_d = IDLE;
              rem_d   = '0;
              done_d  = 1'b1;
            end else begin
              state_d = OFF;
              rem_d   = rem_q - 4'd1;
            end
          end else begin
            dur_d   = dur_q + DUR_W'(1);
            tone_en = 1'b1;
          end
        end
        OFF: begin
          if (dur_q == DUR_W'(OFF_CYC - 1)) begin
            state_d  = ON;
            dur_d    = '0;
            tone_clr = 1'b1;
          end else begin
            dur_d = dur_q + DUR_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          dur_d   = '0;
          rem_d   = '0;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // Tone register is fed straight from next-state decisions so buzzer drops
  // on the same edge that leaves ON.
  tone_div #(.TONE_HALF(TONE_HALF)) u_tone (
    .clk   (clk_100MHz),
    .rst_n (rst_beep),
    .en    (tone_en),
    .clr   (tone_clr),
    .tone  (buzzer)
  );

endmodule

// File: tb/tb_beep_gen.sv
// Bench for beep_gen: time-since-start reference model checked every cycle, plus directed scenarios.
module tb_beep_gen;
  localparam int TH  = 2;
  localparam int ONC = 8;
  localparam int OFC = 6;
  localparam int MXB = 12;

  logic       clk = 1'b0;
  logic       rst_beep = 1'b0;
  logic       start = 1'b0;
  logic [3:0] beep_cnt = 4'd0;
  logic       stop = 1'b0;
  logic       buzzer, beep_busy, beep_done;

  int tests = 0;
  int fails = 0;

  beep_gen #(.TONE_HALF(TH), .ON_CYC(ONC), .OFF_CYC(OFC), .MAX_BEEPS(MXB)) dut (
    .clk_100MHz (clk),
    .rst_beep   (rst_beep),
    .start      (start),
    .beep_cnt   (beep_cnt),
    .stop       (stop),
    .buzzer     (buzzer),
    .beep_busy  (beep_busy),
    .beep_done  (beep_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a sequence is just "cycles elapsed since start" and a beep count.
  bit m_act  = 1'b0;
  bit m_done = 1'b0;
  int m_t    = 0;
  int m_n    = 0;

  function automatic bit m_buz(input int t);
    int off;
    off = t % (ONC + OFC);
    if (off >= ONC) return 1'b0;
    return ((off / TH) % 2) == 0;
  endfunction

  always @(posedge clk or negedge rst_beep) begin
    if (!rst_beep) begin
      m_act = 1'b0; m_done = 1'b0; m_t = 0; m_n = 0;
    end else begin
      m_done = 1'b0;
      if (stop) m_act = 1'b0;
      else if (m_act) begin
        if (m_t + 1 == m_n * ONC + (m_n - 1) * OFC) begin
          m_act = 1'b0; m_done = 1'b1;
        end else m_t++;
      end else if (start && beep_cnt != 0) begin
        m_act = 1'b1; m_t = 0;
        m_n = (int'(beep_cnt) > MXB) ? MXB : int'(beep_cnt);
      end
    end
  end

  always @(negedge clk) begin
    check("model_busy", beep_busy, m_act);
    check("model_buzzer", buzzer, m_act && m_buz(m_t));
    check("model_done", beep_done, m_done);
  end

  task automatic pulse_start(input logic [3:0] n);
    @(negedge clk); start = 1'b1; beep_cnt = n;
    @(negedge clk); start = 1'b0;
  endtask

  // Called at the first negedge after the start edge; samples window cycles.
  task automatic observe(input int window, output int busy_c, output int done_c,
                         output int done_at, output logic [15:0] pat);
    busy_c = 0; done_c = 0; done_at = -1; pat = '0;
    for (int i = 0; i < window; i++) begin
      if (i < 16) pat[15-i] = buzzer;
      if (beep_busy) busy_c++;
      if (beep_done) begin done_c++; if (done_at < 0) done_at = i; end
      @(negedge clk);
    end
  endtask

  int b, d, da;
  logic [15:0] p;

  initial begin
    repeat (2) @(negedge clk);
    #2;
    check("reset_busy", beep_busy, 0);
    check("reset_buzzer", buzzer, 0);
    check("reset_done", beep_done, 0);
    @(negedge clk); rst_beep = 1'b1;
    repeat (2) @(negedge clk);

    pulse_start(4'd3);
    observe(50, b, d, da, p);
    check("three_busy", b, 36);
    check("three_done_cnt", d, 1);
    check("three_done_at", da, 36);
    check("three_pattern", p, 16'b1100110000000011);

    pulse_start(4'd0);
    observe(20, b, d, da, p);
    check("zero_busy", b, 0);
    check("zero_done", d, 0);
    check("zero_pattern", p, 0);

    pulse_start(4'd15);
    observe(180, b, d, da, p);
    check("clamp_busy", b, 162);
    check("clamp_done", d, 1);

    pulse_start(4'd3);
    repeat (19) @(negedge clk);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    check("stop_busy", beep_busy, 0);
    check("stop_buzzer", buzzer, 0);
    observe(20, b, d, da, p);
    check("stop_no_done", d, 0);
    check("stop_idle", b, 0);
    pulse_start(4'd1);
    observe(15, b, d, da, p);
    check("one_busy", b, 8);
    check("one_done", d, 1);
    check("one_pattern", p[15:8], 8'b11001100);

    pulse_start(4'd2);
    b = 0;
    for (int i = 0; i < 30; i++) begin
      if (beep_busy) b++;
      if (i == 10) begin start = 1'b1; beep_cnt = 4'd5; end
      else start = 1'b0;
      @(negedge clk);
    end
    check("reissue_busy", b, 22);

    @(negedge clk); start = 1'b1; stop = 1'b1; beep_cnt = 4'd5;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    check("startstop_busy", beep_busy, 0);
    observe(10, b, d, da, p);
    check("startstop_idle", b, 0);

    pulse_start(4'd3);
    repeat (3) @(negedge clk);
    #2 rst_beep = 1'b0;
    #1;
    check("async_rst_busy", beep_busy, 0);
    check("async_rst_buzzer", buzzer, 0);
    @(negedge clk); rst_beep = 1'b1;
    observe(40, b, d, da, p);
    check("post_rst_idle", b, 0);
    check("post_rst_no_done", d, 0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start    = ($urandom_range(0, 24) == 0);
      beep_cnt = 4'($urandom_range(0, 15));
      stop     = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk); start = 1'b0; stop = 1'b0;
    repeat (200) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/beep_gen.md
# beep_gen

Tone-burst buzzer driver for the digital clock's sound path. It is the output counterpart of the sound-detect input: on a start pulse it drives the buzzer pin with a square-wave tone, emitting a programmed number of beeps. Each beep is one ON burst followed by a silent OFF gap. Typical sources are the hourly chime (1–12 beeps) and the alarm. A stop input silences it immediately.

## Interface
Parameters:
- TONE_HALF, 25_000: clock cycles per tone half-period (2 kHz at 100 MHz).
- ON_CYC, 20_000_000: cycles per beep ON burst (200 ms).
- OFF_CYC, 30_000_000: cycles per gap between beeps (300 ms).
- MAX_BEEPS, 12: clamp for the requested beep count.

Ports:
- clk_100MHz  in  1  system clock.
- rst_beep  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request pulse.
- beep_cnt  in  4  number of beeps, sampled with start.
- stop  in  1  level or pulse; aborts any activity.
- buzzer  out  1  tone output to the buzzer pin.
- beep_busy  out  1  high while a sequence is in progress.
- beep_done  out  1  one-cycle pulse on natural completion.

## Operation
- FSM states: IDLE, ON, OFF. Reset drives state to IDLE and all counters to 0. Reset values: buzzer=0, beep_busy=0, beep_done=0.
- IDLE:
  - start=1 with beep_cnt≠0 → ON. Latch remaining = min(beep_cnt, MAX_BEEPS).
  - start with beep_cnt=0 → stay IDLE, no busy, no done.
- ON:
  - buzzer toggles every TONE_HALF cycles; the first level is 1.
  - After ON_CYC cycles: if remaining=1 → IDLE with beep_done pulse; else remaining−1 → OFF.
- OFF: buzzer held 0. After OFF_CYC cycles → ON, and the tone phase restarts at 1.
- stop has the highest priority. From any state it forces IDLE on the next edge, buzzer=0, and counters cleared. No beep_done is issued.
- start while busy is ignored; a new sequence does not restart or extend the current one.
- start and stop in the same cycle: stop wins, and the block stays IDLE.
- beep_busy=1 exactly while the state is ON or OFF.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Timing
- start sampled at edge k → state ON after edge k. From then, buzzer=1 and beep_busy=1 (one-cycle latency).
- Tone: buzzer is 1 for cycles k..k+TONE_HALF−1, then 0 for the next TONE_HALF cycles, and so on.
- Each ON lasts exactly ON_CYC cycles; each OFF lasts exactly OFF_CYC cycles.
- For n beeps, busy lasts n·ON_CYC + (n−1)·OFF_CYC cycles.
- On the cycle after the final ON ends: beep_busy=0, buzzer=0, beep_done=1 (for one cycle only).
- A tone half-period that is cut short by the ON→OFF transition is truncated; buzzer goes to 0 immediately.
- stop sampled at edge j → buzzer=0 and beep_busy=0 after edge j.
- Deassertion of rst_beep mid-sequence: the block starts in IDLE and the sequence is not resumed.
- Phase and duration counters are sized to $clog2 of their maximum value. They wrap only through explicit reload and never overflow.

## Structure
- Package beep_pkg holds:
  - the state enum (IDLE/ON/OFF);
  - default constants TONE_HALF, ON_CYC and OFF_CYC for 100 MHz;
  - MAX_BEEPS.
- Sub-module tone_div: a square-wave divider with an enable and a synchronous clear (phase restart to 1), parameterised by TONE_HALF.
- The top level holds the FSM, the duration counter and the beep counter.

## Test plan
All scenarios use TONE_HALF=2, ON_CYC=8, OFF_CYC=6, MAX_BEEPS=12.
- Reset asserted mid-burst (rst_beep=0) → buzzer=0, beep_busy=0 immediately (asynchronous); after release, the block is IDLE.
- start, beep_cnt=3 → buzzer pattern 1100 1100 for each ON, 6 zeros between bursts. beep_busy is high for exactly 36 cycles, followed by a single beep_done pulse.
- start, beep_cnt=0 → beep_busy and buzzer stay 0 and no beep_done is issued; beep_cnt=15 → exactly 12 beeps (busy for 162 cycles).
- stop 5 cycles into the second beep → buzzer=0 and beep_busy=0 on the next cycle, with no beep_done. Then start with beep_cnt=1 → a normal 8-cycle beep.
- start reissued during OFF of a 2-beep sequence → ignored; total busy is still 22 cycles. start and stop in the same cycle → the block stays IDLE.
